giu_cxs_loopback_reflector: RTL

Far-end CXS reflector for the GIU loopback path. Accepts 512-bit flits on the CXS-side interface driven by the loopback controller's `loop_out_cxs_in_*` channel, buffers them in a small FIFO, holds each flit for a programmable residency delay, and returns them unchanged on the channel feeding the controller's `cxs_out_loop_in_*` inputs. It stands in for the remote chiplet during far-loop tests, so the controller's compare logic sees a realistic round trip with backpressure.

---
 rtl/giu_loopback_pkg.sv | 29 ++
 rtl/giu_reflect_fifo.sv | 65 ++++++
 rtl/giu_cxs_loopback_reflector.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/giu_loopback_pkg.sv
// Shared types and constants for the GIU loopback path: the reflector FSM
// state encoding and the residency-delay decode.
package giu_loopback_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } loop_state_e;

  localparam int DLY_W = 7;

  localparam logic [DLY_W-1:0] DLY_SEL0 = 7'd0;
  localparam logic [DLY_W-1:0] DLY_SEL1 = 7'd4;
  localparam logic [DLY_W-1:0] DLY_SEL2 = 7'd16;
  localparam logic [DLY_W-1:0] DLY_SEL3 = 7'd64;

  function automatic logic [DLY_W-1:0] decode_delay(input logic [1:0] sel);
    logic [DLY_W-1:0] dly;
    case (sel)
      2'd0:    dly = DLY_SEL0;
      2'd1:    dly = DLY_SEL1;
      2'd2:    dly = DLY_SEL2;
      default: dly = DLY_SEL3;
    endcase
    return dly;
  endfunction

endpackage

// File: rtl/giu_reflect_fifo.sv
// Register FIFO for the loopback reflector: DEPTH entries of DW bits with
// extra-MSB pointers so full and empty are distinguishable without a counter.
module giu_reflect_fifo #(
  parameter int DW    = 512,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] FULL_XOR = {1'b1, {AW{1'b0}}};

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  // NOTE: every always_comb output is assigned a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      wr_ptr_d               = wr_ptr_q + PTR_ONE;
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  // flops sample their inputs from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are valid, and a reset on wide data costs routing.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = ((wr_ptr_q ^ rd_ptr_q) == FULL_XOR);
  assign count     = wr_ptr_q - rd_ptr_q;
  assign head_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/giu_cxs_loopback_reflector.sv
// Far-end CXS reflector: buffers flits, holds each head for a programmable
// residency delay, and returns them. Optional bit-flip injection is built
// when GIU_REFLECT_ERR_INJECT_EN is defined.
module giu_cxs_loopback_reflector
  import giu_loopback_pkg::*;
#(
  parameter int DW    = 512,
  parameter int DEPTH = 4
) (
  input  logic                   clk_clk,
  input  logic                   clk_reset,
  input  logic                   reflect_en,
  input  logic [1:0]             delay_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          out_data,
  input  logic                   err_inject,
  input  logic [8:0]             err_bit_sel,
  output logic                   err_pending,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [16:0]            flit_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   OCC_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [16:0]   FLIT_MAX = 17'h1FFFF;
  localparam logic [DW-1:0] BIT_ONE  = {{(DW-1){1'b0}}, 1'b1};

  loop_state_e      state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [16:0]      flit_count_q, flit_count_d;
  logic             clear_count;

  logic             push, pop, head_load;
  logic             fifo_full, fifo_empty;
  logic [AW:0]      fifo_count;
  logic [DW-1:0]    head_data;
  logic             mask_en;
  logic [8:0]       mask_bit;

  giu_reflect_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk_clk),
    .rst       (clk_reset),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign in_ready  = (state_q == ST_ACTIVE) & reflect_en & ~fifo_full;
  assign out_valid = ~fifo_empty & (dly_q == '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // A new head appears on a write into an empty FIFO, or on a pop that
  // leaves something behind (including the entry written that same cycle).
  assign head_load = (push & fifo_empty) | (pop & ((fifo_count > OCC_ONE) | push));

  always_comb begin
    state_d     = state_q;
    clear_count = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (reflect_en) begin
          state_d     = ST_ACTIVE;
          clear_count = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!reflect_en) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (reflect_en)              state_d = ST_ACTIVE;
        else if (fifo_count == '0)   state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dly_d = dly_q;
    if (head_load)          dly_d = decode_delay(delay_sel);
    else if (dly_q != '0)   dly_d = dly_q - DLY_W'(1);
  end

  always_comb begin
    flit_count_d = flit_count_q;
    if (clear_count)                         flit_count_d = '0;
    else if (pop && flit_count_q != FLIT_MAX) flit_count_d = flit_count_q + 17'd1;
  end

  always_ff @(posedge clk_clk or posedge clk_reset) begin
    if (clk_reset) begin
      state_q      <= ST_IDLE;
      dly_q        <= '0;
      flit_count_q <= '0;
    end else begin
      state_q      <= state_d;
      dly_q        <= dly_d;
      flit_count_q <= flit_count_d;
    end
  end

`ifdef GIU_REFLECT_ERR_INJECT_EN
  logic       err_arm_q, err_arm_d;
  logic [8:0] err_bit_q, err_bit_d;
  logic       held_q, held_d;
  logic       lock_en_q, lock_en_d;
  logic [8:0] lock_bit_q, lock_bit_d;

  // While a presented flit waits for out_ready its mask is frozen, so a new
  // pulse cannot disturb out_data mid-handshake; it waits for a later flit.
  assign mask_en  = held_q ? lock_en_q  : err_arm_q;
  assign mask_bit = held_q ? lock_bit_q : err_bit_q;

  always_comb begin
    err_arm_d  = err_arm_q & ~(pop & mask_en);
    err_bit_d  = err_bit_q;
    if (err_inject) begin
      err_arm_d = 1'b1;
      err_bit_d = err_bit_sel;
    end
    held_d     = out_valid & ~out_ready;
    lock_en_d  = mask_en;
    lock_bit_d = mask_bit;
  end

  always_ff @(posedge clk_clk or posedge clk_reset) begin
    if (clk_reset) begin
      err_arm_q  <= 1'b0;
      err_bit_q  <= '0;
      held_q     <= 1'b0;
      lock_en_q  <= 1'b0;
      lock_bit_q <= '0;
    end else begin
      err_arm_q  <= err_arm_d;
      err_bit_q  <= err_bit_d;
      held_q     <= held_d;
      lock_en_q  <= lock_en_d;
      lock_bit_q <= lock_bit_d;
    end
  end

  assign err_pending = err_arm_q;
`else
  logic unused_err_in;
  assign unused_err_in = ^{err_inject, err_bit_sel};
  assign mask_en       = 1'b0;
  assign mask_bit      = '0;
  assign err_pending   = 1'b0;
`endif

  assign out_data   = out_valid ? (head_data ^ (mask_en ? (BIT_ONE << mask_bit) : '0)) : '0;
  assign busy       = (state_q != ST_IDLE);
  assign occupancy  = fifo_count;
  assign flit_count = flit_count_q;

endmodule
